// File: rtl/voq_ingress_writer.sv
// voq_ingress_writer
//   Ingress side of one crossbar input port. Parses a zero-terminated packet
//   stream and writes each packet into the virtual-output-queue RAM named by
//   the low bits of its header word. Publishes a committed fill pointer per
//   RAM, which the scheduler compares against its read addresses.
//
//   State table:
//     S_IDLE | between packets; zero words are filler, nonzero word is a header
//     S_FWD  | storing a packet into the RAM latched from its header
//     S_DROP | discarding words up to and including the next zero word
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   reset_rams          synchronous clear of all write pointers
//   in_data/in_valid    ingress word stream
//   in_ready            high unless a reset is active (no back-pressure)
//   ram_wr_data         shared write data bus to all VOQ RAMs
//   ram_wren            one-hot write enable, one bit per RAM
//   ram_wr_addr         per-RAM write address, packed NPORT x ADDR_W
//   wr_add              per-RAM committed fill pointer, packed NPORT x ADDR_W
//   pkt_count           packets stored (saturating)
//   drop_count          packets dropped or truncated (saturating)
module voq_ingress_writer #(
    parameter int NPORT   = 4,
    parameter int ADDR_W  = 12,
    parameter int MAX_PKT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reset_rams,
    input  logic [31:0]               in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [31:0]               ram_wr_data,
    output logic [NPORT-1:0]          ram_wren,
    output logic [NPORT*ADDR_W-1:0]   ram_wr_addr,
    output logic [NPORT*ADDR_W-1:0]   wr_add,
    output logic [CNT_W-1:0]          pkt_count,
    output logic [CNT_W-1:0]          drop_count
);

    localparam int PW     = ADDR_W + 1;            // pointer can reach DEPTH
    localparam int WCW    = $clog2(MAX_PKT) + 1;
    localparam int DEST_W = $clog2(NPORT);

    localparam logic [PW-1:0]  DEPTH_P  = PW'(1 << ADDR_W);
    localparam logic [PW-1:0]  MAX_P    = PW'(MAX_PKT);
    localparam logic [WCW-1:0] WC_LAST  = WCW'(MAX_PKT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FWD  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]        state, state_n;
    logic [DEST_W-1:0] dest, dest_n;
    logic [WCW-1:0]    word_cnt, cnt_n;
    logic [PW-1:0]     nxt [NPORT];
    logic [NPORT-1:0]  wren_q, wren_n;
    logic [31:0]       wr_word;
    logic              do_write;
    logic [DEST_W-1:0] wr_dest;
    logic              inc_pkt, inc_drop;
    logic              accept;
    logic [DEST_W-1:0] hdr_dest;
    logic [PW-1:0]     space;

    assign in_ready = !reset && !reset_rams;
    assign accept   = in_valid && in_ready;
    assign hdr_dest = in_data[DEST_W-1:0];
    assign space    = DEPTH_P - nxt[hdr_dest];

    // The write registered from the previous cycle is masked while either
    // reset is active, so a reset_rams pulse cancels a pending write.
    assign ram_wren = (reset || reset_rams) ? '0 : wren_q;

    always_comb begin
        state_n  = state;
        dest_n   = dest;
        cnt_n    = word_cnt;
        do_write = 1'b0;
        wr_dest  = dest;
        wr_word  = in_data;
        inc_pkt  = 1'b0;
        inc_drop = 1'b0;
        if (accept) begin
            case (state)
                S_IDLE: begin
                    if (in_data != '0) begin
                        if (space >= MAX_P) begin
                            do_write = 1'b1;
                            wr_dest  = hdr_dest;
                            dest_n   = hdr_dest;
                            cnt_n    = WCW'(1);
                            state_n  = S_FWD;
                        end else begin
                            inc_drop = 1'b1;
                            state_n  = S_DROP;
                        end
                    end
                end
                S_FWD: begin
                    do_write = 1'b1;
                    if (word_cnt == WC_LAST) begin
                        // Last slot always holds a terminator so the
                        // scheduler can end the packet.
                        wr_word = '0;
                        if (in_data != '0) begin
                            inc_drop = 1'b1;
                            state_n  = S_DROP;
                        end else begin
                            inc_pkt  = 1'b1;
                            state_n  = S_IDLE;
                        end
                    end else if (in_data == '0) begin
                        inc_pkt = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = word_cnt + WCW'(1);
                    end
                end
                S_DROP: begin
                    if (in_data == '0)
                        state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
        wren_n = do_write ? (NPORT'(1) << wr_dest) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            dest        <= '0;
            word_cnt    <= '0;
            wren_q      <= '0;
            ram_wr_data <= '0;
            ram_wr_addr <= '0;
            wr_add      <= '0;
            pkt_count   <= '0;
            drop_count  <= '0;
            for (int d = 0; d < NPORT; d++)
                nxt[d] <= '0;
        end else if (reset_rams) begin
            state       <= S_IDLE;
            wren_q      <= '0;
            ram_wr_addr <= '0;
            wr_add      <= '0;
            for (int d = 0; d < NPORT; d++)
                nxt[d] <= '0;
        end else begin
            state    <= state_n;
            dest     <= dest_n;
            word_cnt <= cnt_n;
            wren_q   <= wren_n;
            if (do_write)
                ram_wr_data <= wr_word;
            for (int d = 0; d < NPORT; d++) begin
                // Committed pointer trails nxt by one cycle, i.e. it only
                // covers a word once that word's write cycle has completed.
                wr_add[d*ADDR_W +: ADDR_W] <= nxt[d][ADDR_W-1:0];
                if (wren_n[d]) begin
                    ram_wr_addr[d*ADDR_W +: ADDR_W] <= nxt[d][ADDR_W-1:0];
                    nxt[d] <= nxt[d] + PW'(1);
                end
            end
            if (inc_pkt && (pkt_count != '1))
                pkt_count <= pkt_count + CNT_W'(1);
            if (inc_drop && (drop_count != '1))
                drop_count <= drop_count + CNT_W'(1);
        end
    end

endmodule
